// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: default widths,
// FSM state codes, forwarding select encodings and the register-control bundle.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF  = 5;
    localparam int MEM_TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF       = 16;

    // FSM state codes
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Pipeline register controls: hold = en 0, bubble = en 1 + clr 1, pass = en 1 + clr 0
    typedef struct packed {
        logic en_f;
        logic en_fd;
        logic clr_fd;
        logic en_de;
        logic clr_de;
        logic en_em;
        logic en_mw;
        logic clr_mw;
    } pipe_ctrl_t;

    // Every stage passes, nothing cleared
    function automatic pipe_ctrl_t ctrl_pass();
        pipe_ctrl_t c;
        c        = '0;
        c.en_f   = 1'b1;
        c.en_fd  = 1'b1;
        c.en_de  = 1'b1;
        c.en_em  = 1'b1;
        c.en_mw  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register. The MEM-stage result
// is younger than the WB-stage result, so it wins when both match.
module fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs_e_i,
    input  logic                  reg_write_m_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic                  reg_write_w_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    output logic [1:0]            fwd_o
);

    // Register 0 is hard-wired, never forwarded
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i))
            fwd_o = FWD_MEM;
        else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i))
            fwd_o = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: MEM-wait stall with timeout, load-use stall,
// branch flush, operand forwarding and saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  load_e,
    input  logic                  pc_src_e,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  mem_req_m,
    input  logic                  mem_ready_m,
    output logic                  en_f,
    output logic                  en_fd,
    output logic                  clr_fd,
    output logic                  en_de,
    output logic                  clr_de,
    output logic                  en_em,
    output logic                  en_mw,
    output logic                  clr_mw,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
    logic              mem_stall, load_use;
    pipe_ctrl_t        ctrl;

    assign wcnt_inc = wcnt_q + WAIT_W'(1);

    // MEM stalls on the entry cycle and on every waiting cycle whose access
    // has not completed; a completing cycle lets the pipeline advance.
    assign mem_stall = !mem_ready_m &&
                       ((state_q == ST_MEM_WAIT) || (state_q == ST_RUN && mem_req_m));

    assign load_use  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req_m && !mem_ready_m) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready_m) begin
                    state_d = ST_RUN;
                end else begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == WAIT_W'(MEM_TIMEOUT))
                        state_d = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    // Register controls by priority: timeout, MEM wait, branch, load-use
    always_comb begin
        ctrl = ctrl_pass();
        if (state_q == ST_TIMEOUT) begin
            ctrl = '0;
        end else if (mem_stall) begin
            ctrl        = '0;
            ctrl.en_mw  = 1'b1;
            ctrl.clr_mw = 1'b1;
        end else if (pc_src_e) begin
            ctrl.clr_fd = 1'b1;
            ctrl.clr_de = 1'b1;
        end else if (load_use) begin
            ctrl.en_f   = 1'b0;
            ctrl.en_fd  = 1'b0;
            ctrl.clr_de = 1'b1;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!ctrl.en_fd && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
        if ((ctrl.clr_fd || ctrl.clr_de) && (flush_q != '1))
            flush_d = flush_q + CNT_W'(1);
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_e_i        (rs1_e),
        .reg_write_m_i (reg_write_m),
        .rd_m_i        (rd_m),
        .reg_write_w_i (reg_write_w),
        .rd_w_i        (rd_w),
        .fwd_o         (fwd_a_e)
    );

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_e_i        (rs2_e),
        .reg_write_m_i (reg_write_m),
        .rd_m_i        (rd_m),
        .reg_write_w_i (reg_write_w),
        .rd_w_i        (rd_w),
        .fwd_o         (fwd_b_e)
    );

    assign en_f        = ctrl.en_f;
    assign en_fd       = ctrl.en_fd;
    assign clr_fd      = ctrl.clr_fd;
    assign en_de       = ctrl.en_de;
    assign clr_de      = ctrl.clr_de;
    assign en_em       = ctrl.en_em;
    assign en_mw       = ctrl.en_mw;
    assign clr_mw      = ctrl.clr_mw;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign mem_timeout = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, checked
// every cycle against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int AW    = 5;
    localparam int TMO   = 255;
    localparam int CW    = 16;
    localparam int SATV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          load_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m;
    logic          en_f, en_fd, clr_fd, en_de, clr_de, en_em, en_mw, clr_mw, mem_timeout;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .pc_src_e(pc_src_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .rd_m(rd_m), .rd_w(rd_w),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .en_f(en_f), .en_fd(en_fd), .clr_fd(clr_fd), .en_de(en_de), .clr_de(clr_de),
        .en_em(en_em), .en_mw(en_mw), .clr_mw(clr_mw),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    int checks = 0;
    int errors = 0;
    bit do_chk = 1'b1;

    // Reference model state: waiting for memory, stall cycles spent waiting, timed out
    bit m_wait, m_to;
    int m_waited, m_stall, m_flush;
    // Expected controls for the current cycle
    bit e_en_f, e_en_fd, e_clr_fd, e_en_de, e_clr_de, e_en_em, e_en_mw, e_clr_mw, e_mstall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_to = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic compute_exp();
        bit lu;
        lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        e_mstall = !m_to && !mem_ready_m && (m_wait || mem_req_m);
        {e_en_f, e_en_fd, e_clr_fd, e_en_de, e_clr_de, e_en_em, e_en_mw, e_clr_mw} = 8'b1101_0110;
        if (m_to)
            {e_en_f, e_en_fd, e_clr_fd, e_en_de, e_clr_de, e_en_em, e_en_mw, e_clr_mw} = 8'b0;
        else if (e_mstall)
            {e_en_f, e_en_fd, e_clr_fd, e_en_de, e_clr_de, e_en_em, e_en_mw, e_clr_mw} = 8'b0000_0011;
        else if (pc_src_e)
            {e_en_f, e_en_fd, e_clr_fd, e_en_de, e_clr_de, e_en_em, e_en_mw, e_clr_mw} = 8'b1111_1110;
        else if (lu)
            {e_en_f, e_en_fd, e_clr_fd, e_en_de, e_clr_de, e_en_em, e_en_mw, e_clr_mw} = 8'b0001_1110;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic run_cycle();
        @(negedge clk);
        compute_exp();
        if (do_chk) begin
            check("en_f", en_f, e_en_f);
            check("en_fd", en_fd, e_en_fd);
            check("clr_fd", clr_fd, e_clr_fd);
            check("en_de", en_de, e_en_de);
            check("clr_de", clr_de, e_clr_de);
            check("en_em", en_em, e_en_em);
            check("en_mw", en_mw, e_en_mw);
            check("clr_mw", clr_mw, e_clr_mw);
            check("fwd_a_e", fwd_a_e, fwd_ref(rs1_e));
            check("fwd_b_e", fwd_b_e, fwd_ref(rs2_e));
            check("stall_cnt", stall_cnt, m_stall);
            check("flush_cnt", flush_cnt, m_flush);
            check("mem_timeout", mem_timeout, m_to);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!e_en_fd && m_stall < SATV) m_stall++;
            if ((e_clr_fd || e_clr_de) && m_flush < SATV) m_flush++;
            if (!m_to) begin
                if (e_mstall) begin
                    m_wait = 1;
                    m_waited++;
                    if (m_waited == TMO + 1) m_to = 1;
                end else begin
                    m_wait = 0;
                    m_waited = 0;
                end
            end
        end
        #1;
    endtask

    task automatic quiet();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        load_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem_req_m = 0; mem_ready_m = 1;
    endtask

    initial begin
        rst = 1; quiet();
        @(posedge clk); #1;
        model_reset();
        run_cycle();
        // Reset state
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_mem_timeout", mem_timeout, 0);
        check("rst_en_f", en_f, 1);
        rst = 0;
        run_cycle();

        // Load-use on rs2
        load_e = 1; rd_e = 5; rs2_d = 5; rs1_d = 3; #1;
        check("lu_en_f", en_f, 0);
        check("lu_en_fd", en_fd, 0);
        check("lu_clr_de", clr_de, 1);
        run_cycle();
        check("lu_stall_cnt", stall_cnt, 1);

        // Load-use together with a taken branch
        pc_src_e = 1; #1;
        check("br_en_f", en_f, 1);
        check("br_clr_fd", clr_fd, 1);
        check("br_clr_de", clr_de, 1);
        run_cycle();
        check("br_stall_cnt", stall_cnt, 1);
        check("br_flush_cnt", flush_cnt, 2);
        quiet();

        // Load-use with rd_e = 0 is not a hazard
        load_e = 1; rd_e = 0; rs1_d = 0; #1;
        check("lu_r0_en_fd", en_fd, 1);
        run_cycle();
        quiet();

        // MEM wait for 3 cycles, then completion
        mem_req_m = 1; mem_ready_m = 0; load_e = 1; rd_e = 4; rs1_d = 4; pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_en_em", en_em, 0);
            check("mw_clr_mw", clr_mw, 1);
            check("mw_clr_de", clr_de, 0);
            run_cycle();
        end
        quiet(); mem_req_m = 1; mem_ready_m = 1; #1;
        check("mw_done_en_f", en_f, 1);
        check("mw_done_en_em", en_em, 1);
        check("mw_done_clr_mw", clr_mw, 0);
        run_cycle();
        quiet();

        // Forwarding priority
        reg_write_m = 1; reg_write_w = 1; rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 7; #1;
        check("fwd_mem", fwd_a_e, 2'b10);
        run_cycle();
        rd_m = 0; #1;
        check("fwd_wb", fwd_a_e, 2'b01);
        check("fwd_wb_b", fwd_b_e, 2'b01);
        run_cycle();
        quiet();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
            rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
            rd_e  = AW'($urandom_range(0, 3)); rd_m  = AW'($urandom_range(0, 3));
            rd_w  = AW'($urandom_range(0, 3));
            load_e = ($urandom_range(0, 2) == 0); pc_src_e = ($urandom_range(0, 4) == 0);
            reg_write_m = $urandom_range(0, 1); reg_write_w = $urandom_range(0, 1);
            mem_req_m = ($urandom_range(0, 3) == 0); mem_ready_m = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        quiet();
        run_cycle();

        // Reset aborts a MEM wait
        mem_req_m = 1; mem_ready_m = 0;
        repeat (5) run_cycle();
        rst = 1;
        run_cycle();
        rst = 0; mem_req_m = 0; #1;
        check("abort_en_f", en_f, 1);
        check("abort_en_em", en_em, 1);
        run_cycle();

        // Timeout after 256 cycles of memory not ready
        mem_req_m = 1; mem_ready_m = 0;
        repeat (255) run_cycle();
        #1; check("tmo_before", mem_timeout, 0);
        run_cycle();
        #1; check("tmo_set", mem_timeout, 1);
        check("tmo_en_mw", en_mw, 0);
        mem_ready_m = 1;
        repeat (3) run_cycle();
        #1; check("tmo_sticky", mem_timeout, 1);
        rst = 1; #1;
        check("tmo_rst_cycle", mem_timeout, 1);
        run_cycle();
        rst = 0; quiet(); #1;
        check("tmo_cleared", mem_timeout, 0);
        check("tmo_clr_en_f", en_f, 1);
        run_cycle();

        // Counter saturation under continuous load-use
        load_e = 1; rd_e = 5; rs1_d = 5;
        for (int i = 0; i < 70000; i++) begin
            do_chk = (i % 8192 == 0) || (i > 69990);
            run_cycle();
        end
        do_chk = 1;
        #1;
        check("sat_stall_cnt", stall_cnt, 16'hFFFF);
        check("sat_flush_cnt", flush_cnt, 16'hFFFF);
        run_cycle();
        check("sat_stall_held", stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of MEM_WAIT cycles before a timeout.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the performance-counter width.
REQ-004 SHALL have ports: clk  in  1  clock, single domain; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: rs1_d, rs2_d  in  REG_ADDR_W  decode-stage sources; rs1_e, rs2_e, rd_e  in  REG_ADDR_W  execute-stage indices.
REQ-006 SHALL have ports: load_e  in  1  EX holds a load; pc_src_e  in  1  branch/jump taken in EX.
REQ-007 SHALL have ports: reg_write_m, reg_write_w  in  1; rd_m, rd_w  in  REG_ADDR_W  writeback intent per stage.
REQ-008 SHALL have ports: mem_req_m  in  1  data access in MEM; mem_ready_m  in  1  data memory completes this cycle.
REQ-009 SHALL have ports: en_f  out  1  PC enable; en_fd, clr_fd, en_de, clr_de, en_em, en_mw, clr_mw  out  1  pipeline register controls.
REQ-010 SHALL have ports: fwd_a_e, fwd_b_e  out  2  ALU operand select (00 register file, 01 WB, 10 MEM).
REQ-011 SHALL have ports: stall_cnt, flush_cnt  out  CNT_W  counters; mem_timeout  out  1  sticky error.
REQ-012 SHALL drive the register control contract as: stage hold = en 0; bubble = en 1 with clr 1; pass = en 1 with clr 0. Clr is ignored while en is 0.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT, TIMEOUT; all control outputs are combinational from state and inputs; state and counters are registered.
REQ-014 SHALL transition RUN->MEM_WAIT when mem_req_m=1 and mem_ready_m=0, MEM_WAIT->RUN on mem_ready_m=1, and MEM_WAIT->TIMEOUT when the wait counter reaches MEM_TIMEOUT.
REQ-015 SHALL, in MEM_WAIT (and in RUN on the entry cycle), drive en_f, en_fd, en_de, en_em to 0 and en_mw=1, clr_mw=1 (WB bubble); MEM wait takes priority over all other hazards.
REQ-016 SHALL detect load-use as load_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d); the response is en_f=0, en_fd=0, en_de=1, clr_de=1.
REQ-017 SHALL respond to pc_src_e=1 with en_f=1, en_fd=1, clr_fd=1, en_de=1, clr_de=1; this overrides load-use in the same cycle.
REQ-018 SHALL, with no hazard, drive all en to 1 and all clr to 0.
REQ-019 SHALL compute forwarding as: fwd_a_e=10 if reg_write_m & rd_m!=0 & rd_m==rs1_e; else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e; else 00. fwd_b_e uses rs2_e identically. MEM wins when both match.
REQ-020 SHALL, in TIMEOUT, drive all en to 0 and mem_timeout=1, and hold until rst.
REQ-021 SHALL increment stall_cnt once per cycle in which en_fd=0, and flush_cnt once per cycle in which clr_fd|clr_de=1; both saturate at all-ones and never wrap.
REQ-022 SHALL reload the wait counter to 0 on each entry to MEM_WAIT; its width is clog2(MEM_TIMEOUT+1).

Reset
REQ-023 SHALL, on rst=1 at a clk edge, set state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0; outputs then follow RUN rules.
REQ-024 SHALL let rst abort MEM_WAIT or TIMEOUT mid-operation with no residual stall on the following cycle.

Structure
REQ-025 SHALL place the FSM state enumeration, the fwd select encodings (FWD_RF, FWD_WB, FWD_MEM), and the default widths in the shared datapath package.
REQ-026 SHALL implement forwarding as one sub-module, fwd_unit, instantiated twice (operands A and B).

Verification
REQ-027 SHALL cover: load_e=1, rd_e=5, rs2_d=5 -> en_f=0, en_fd=0, clr_de=1, stall_cnt +1.
REQ-028 SHALL cover: load-use plus pc_src_e=1 in the same cycle -> en_f=1, clr_fd=1, clr_de=1, flush_cnt +1, stall_cnt unchanged.
REQ-029 SHALL cover: mem_req_m=1 with mem_ready_m low for 3 cycles -> 3 cycles with en_em=0 and clr_mw=1, then RUN with all en=1.
REQ-030 SHALL cover: mem_ready_m held low for 256 cycles -> mem_timeout=1 from cycle 256 onward; rst clears it next edge.
REQ-031 SHALL cover: rd_m=rd_w=7, both writing, rs1_e=7 -> fwd_a_e=10; same with rd_m=0 -> fwd_a_e=01.
REQ-032 SHALL cover: 70000 consecutive load-use stalls -> stall_cnt=16'hFFFF, held.
